// File: rtl/bcd_step_counter.sv
// Single-digit BCD up/down counter with prescaler, load and error flag.
// Drives a 1-of-10 decoder: A is the address, WD the active-low enable.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   en     count enable, gates the prescaler
//   up     1 = increment, 0 = decrement
//   load   synchronous load strobe for din
//   din    BCD load value (10..15 rejected, sets err)
//   blank  request to disable the decoder (WD follows one cycle later)
//   A      registered BCD digit 0..9
//   WD     registered decoder disable, 1 = all decoder outputs low
//   co     one-cycle wrap pulse (carry up / borrow down)
//   err    sticky out-of-range load flag

module bcd_step_counter #(
    parameter int unsigned DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] din,
    input  logic       blank,
    output logic [3:0] A,
    output logic       WD,
    output logic       co,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    localparam logic [7:0] P_LAST = 8'(DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] p_q, p_d;
    logic [3:0] a_q, a_d;
    logic       co_q, co_d;
    logic       err_q, err_d;
    logic       wd_q, wd_d;

    logic load_ok;
    logic load_bad;
    logic tick;

    assign load_ok  = load && (din <= 4'd9);
    assign load_bad = load && (din > 4'd9);
    // Any load, valid or not, wins over a coincident tick.
    assign tick     = en && !load && (p_q == P_LAST);

    always_comb begin
        a_d   = a_q;
        p_d   = p_q;
        co_d  = 1'b0;
        err_d = err_q;
        if (load_ok) begin
            a_d   = din;
            p_d   = 8'd0;
            err_d = 1'b0;
        end else if (load_bad) begin
            // Rejected load freezes digit and prescaler.
            err_d = 1'b1;
        end else if (tick) begin
            p_d = 8'd0;
            if (up) begin
                if (a_q == 4'd9) begin
                    a_d  = 4'd0;
                    co_d = 1'b1;
                end else begin
                    a_d = a_q + 4'd1;
                end
            end else begin
                if (a_q == 4'd0) begin
                    a_d  = 4'd9;
                    co_d = 1'b1;
                end else begin
                    a_d = a_q - 4'd1;
                end
            end
        end else if (en) begin
            p_d = p_q + 8'd1;
        end
    end

    // The FSM only governs the decoder enable; counting is
    // handled by the prescaler regardless of state.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        unique case (state_q)
            IDLE: begin
                wd_d = 1'b1;
                if (en || load_ok) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                wd_d = blank;
                if (!en) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                wd_d = blank;
                if (en) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                wd_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= 8'd0;
            a_q     <= 4'd0;
            co_q    <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            a_q     <= a_d;
            co_q    <= co_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    assign A   = a_q;
    assign WD  = wd_q;
    assign co  = co_q;
    assign err = err_q;

endmodule

// File: tb/tb_bcd_step_counter.sv
// Self-checking bench for bcd_step_counter (DIV=4).
// Directed sequences, a load vector table and randomized traffic.

module tb_bcd_step_counter;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] din = 4'd0;
    logic       blank = 1'b0;
    logic [3:0] A;
    logic       WD;
    logic       co;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int m_a, m_cnt, m_co, m_err, m_wd, m_started;

    typedef struct {
        logic [3:0] din;
        int         a;
        int         err;
    } vec_t;

    vec_t tbl[7];

    bcd_step_counter #(.DIV(DIV)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .up   (up),
        .load (load),
        .din  (din),
        .blank(blank),
        .A    (A),
        .WD   (WD),
        .co   (co),
        .err  (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_a       = 0;
        m_cnt     = 0;
        m_co      = 0;
        m_err     = 0;
        m_wd      = 1;
        m_started = 0;
    endtask

    // One clock edge of the digit counter, from the behavioural rules.
    task automatic model_edge();
        int wd_n;
        int vld;
        vld  = (load && din <= 9) ? 1 : 0;
        wd_n = m_started ? int'(blank) : 1;
        m_co = 0;
        if (load) begin
            if (din <= 9) begin
                m_a   = int'(din);
                m_cnt = 0;
                m_err = 0;
            end else begin
                m_err = 1;
            end
        end else if (en) begin
            m_cnt++;
            if (m_cnt == DIV) begin
                m_cnt = 0;
                if (up) begin
                    m_co = (m_a == 9) ? 1 : 0;
                    m_a  = (m_a + 1) % 10;
                end else begin
                    m_co = (m_a == 0) ? 1 : 0;
                    m_a  = (m_a + 9) % 10;
                end
            end
        end
        m_wd = wd_n;
        if (en || vld) m_started = 1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_A", int'(A), m_a);
        chk("model_WD", int'(WD), m_wd);
        chk("model_co", int'(co), m_co);
        chk("model_err", int'(err), m_err);
    endtask

    // Entered at a time away from clock edges.
    task automatic do_reset();
        en    = 1'b0;
        up    = 1'b0;
        load  = 1'b0;
        din   = 4'd0;
        blank = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_A", int'(A), 0);
        chk("rst_WD", int'(WD), 1);
        chk("rst_co", int'(co), 0);
        chk("rst_err", int'(err), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        int k;
        int frozen;
        int ncarry;

        tbl[0] = '{din: 4'd7,  a: 7, err: 0};
        tbl[1] = '{din: 4'd12, a: 7, err: 1};
        tbl[2] = '{din: 4'd15, a: 7, err: 1};
        tbl[3] = '{din: 4'd3,  a: 3, err: 0};
        tbl[4] = '{din: 4'd10, a: 3, err: 1};
        tbl[5] = '{din: 4'd9,  a: 9, err: 0};
        tbl[6] = '{din: 4'd0,  a: 0, err: 0};

        #2;
        do_reset();

        // Free-running ramp from reset.
        en     = 1'b1;
        up     = 1'b1;
        ncarry = 0;
        for (int i = 1; i <= 40; i++) begin
            step();
            chk("ramp_A", int'(A), (i / DIV) % 10);
            chk("ramp_co", int'(co), (i == 40) ? 1 : 0);
            chk("ramp_WD", int'(WD), (i == 1) ? 1 : 0);
            if (co) ncarry++;
        end
        chk("ramp_carries", ncarry, 1);

        // Borrow 0 -> 9.
        up = 1'b0;
        for (int i = 1; i <= DIV; i++) begin
            step();
        end
        chk("borrow_A", int'(A), 9);
        chk("borrow_co", int'(co), 1);
        step();
        chk("borrow_co_end", int'(co), 0);

        // Load coincident with a tick: load wins, prescaler restarts.
        up = 1'b1;
        k  = 0;
        while (m_cnt != DIV - 1 && k < 20) begin
            step();
            k++;
        end
        chk("phase_found", (m_cnt == DIV - 1) ? 1 : 0, 1);
        load = 1'b1;
        din  = 4'd7;
        step();
        chk("ldtick_A", int'(A), 7);
        chk("ldtick_co", int'(co), 0);
        load = 1'b0;
        for (int i = 1; i < DIV; i++) begin
            step();
            chk("ldtick_hold", int'(A), 7);
        end
        step();
        chk("ldtick_next", int'(A), 8);

        // Pause: digit frozen, then resume with blank.
        frozen = int'(A);
        en     = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("pause_A", int'(A), frozen);
        end
        en    = 1'b1;
        blank = 1'b1;
        step();
        chk("blank_WD", int'(WD), 1);
        for (int i = 1; i < 2 * DIV; i++) begin
            step();
        end
        chk("resume_A", int'(A), (frozen + 2) % 10);
        blank = 1'b0;
        step();
        chk("unblank_WD", int'(WD), 0);

        // Asynchronous reset mid-count at A=6 with err set.
        load = 1'b1;
        din  = 4'd5;
        step();
        load = 1'b0;
        k    = 0;
        while (m_a != 6 && k < 20) begin
            step();
            k++;
        end
        chk("reach6", int'(A), 6);
        load = 1'b1;
        din  = 4'd14;
        step();
        load = 1'b0;
        chk("bad_err", int'(err), 1);
        chk("bad_A", int'(A), 6);
        #2;
        do_reset();

        // Fresh start: first tick after DIV enabled cycles.
        en = 1'b1;
        up = 1'b1;
        for (int i = 1; i <= DIV; i++) begin
            step();
            chk("fresh_A", int'(A), (i == DIV) ? 1 : 0);
        end

        // Load vector table.
        #2;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            load = 1'b1;
            din  = tbl[i].din;
            step();
            chk("tbl_A", int'(A), tbl[i].a);
            chk("tbl_err", int'(err), tbl[i].err);
            chk("tbl_co", int'(co), 0);
        end
        load = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            en    = ($urandom_range(0, 3) != 0);
            up    = ($urandom_range(0, 7) != 0) ? up : ~up;
            load  = ($urandom_range(0, 7) == 0);
            din   = 4'($urandom_range(0, 15));
            blank = ($urandom_range(0, 5) == 0);
            step();
            chk("rand_range", (A <= 4'd9) ? 1 : 0, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_step_counter.md
BCD_STEP_COUNTER -- requirements
Module: bcd_step_counter

Interface
REQ-001 SHALL provide parameter DIV, default 4, giving clock cycles per count step (legal range 1..255).
REQ-002 SHALL provide port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port en  input  1  count enable; gates the prescaler.
REQ-005 SHALL provide port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-006 SHALL provide port load  input  1  synchronous load strobe for din.
REQ-007 SHALL provide port din  input  4  BCD load value.
REQ-008 SHALL provide port blank  input  1  request to disable the downstream 1-of-10 decoder.
REQ-009 SHALL provide port A  output  4  current BCD digit 0..9, registered, drives decoder address.
REQ-010 SHALL provide port WD  output  1  registered active-low decoder enable; 1 = all decoder outputs low.
REQ-011 SHALL provide port co  output  1  one-cycle wrap pulse (carry when counting up, borrow when counting down).
REQ-012 SHALL provide port err  output  1  sticky flag: an out-of-range load was attempted.

Function
REQ-013 SHALL hold A within 0..9 at all times; values 10..15 never appear on A.
REQ-014 SHALL keep an internal prescaler p (0..DIV-1): while en=1, p increments each cycle; at p=DIV-1 a tick occurs and p returns to 0; while en=0, p holds.
REQ-015 SHALL, on a tick with up=1, set A to A+1, or to 0 when A=9.
REQ-016 SHALL, on a tick with up=0, set A to A-1, or to 9 when A=0.
REQ-017 SHALL assert co for exactly the one cycle in which A first shows the wrapped value (9->0 or 0->9); co=0 otherwise.
REQ-018 SHALL treat load as higher priority than a tick in the same cycle.
REQ-019 SHALL, on load=1 with din<=9: A=din next cycle, p=0, co=0, err cleared.
REQ-020 SHALL, on load=1 with din>=10: leave A and p unchanged, suppress any coincident tick, co=0, set err=1.
REQ-021 SHALL keep err set until reset or a valid load.
REQ-022 SHALL implement FSM with states IDLE, RUN, PAUSE.
REQ-023 IDLE -> RUN on en=1 or valid load; IDLE ignores blank and forces WD=1.
REQ-024 RUN -> PAUSE when en=0; PAUSE -> RUN when en=1; no other transitions except reset.
REQ-025 SHALL, in RUN and PAUSE, register WD <= blank (one-cycle latency from blank to WD).
REQ-026 SHALL hold A in PAUSE; load remains honoured in PAUSE, and the state stays PAUSE.
REQ-027 SHALL, with DIV=1, tick every cycle while en=1.
REQ-028 SHALL change direction at the next tick when up toggles; no pending state is kept.

Reset
REQ-029 SHALL, while rst_n=0 (asynchronous): A=0, WD=1, co=0, err=0, p=0, state IDLE.
REQ-030 SHALL treat rst_n deasserting mid-count as a fresh start: first tick after DIV cycles of en=1.
REQ-031 SHALL release reset synchronously: no state change on the first clk edge where rst_n is sampled low-to-high metastable-free (external synchroniser assumed by system).

Verification
REQ-032 DIV=4, reset, en=1, up=1, blank=0 for 40 cycles -> A steps 0,1,..,9,0 every 4 cycles; co high exactly one cycle when A becomes 0; WD=0 from the cycle after leaving IDLE.
REQ-033 A=0, up=0, tick -> A=9, co=1 for one cycle.
REQ-034 load=1, din=7, coincident with tick -> A=7, co=0, p=0; next tick 4 cycles later gives A=8.
REQ-035 load=1, din=12 -> A unchanged, err=1; later load din=3 -> A=3, err=0.
REQ-036 RUN, en=0 for 10 cycles then en=1 -> A frozen, p resumes from held value; blank=1 -> WD=1 one cycle later, A keeps counting.
REQ-037 rst_n pulsed low mid-count at A=6 -> A=0, WD=1, err=0, co=0 immediately, without waiting for clk.
